// File: rtl/prg_upload.sv
// rtl/prg_upload.sv - PRG image uploader: zero-page pointer fetch, memory read, SPI slave shift-out
// Optional feature macro: UPLOAD_CHECKSUM_EN (appends an XOR trailer byte to the stream).

module prg_upload #(
   parameter logic [15:0] PTR_BASE    = 16'h002B,
   parameter logic [7:0]  PAD_BYTE    = 8'hFF,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        underrun,
   output logic [15:0] upload_len,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_data,
   input  logic        mem_ack,
   input  logic        sck,
   input  logic        ss,
   output logic        sdo
);

   typedef enum logic [2:0] {
      S_IDLE, S_PTR0, S_PTR1, S_PTR2, S_PTR3, S_STREAM, S_FLUSH
   } state_t;

`ifdef UPLOAD_CHECKSUM_EN
   localparam logic [16:0] TRAILER = 17'd1;
`else
   localparam logic [16:0] TRAILER = 17'd0;
`endif

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q;
   logic        sck_prev_q, ss_prev_q;
   logic        sck_s, ss_s, sck_rise, sck_fall, ss_rise, ss_fall;

   logic        mem_rd_q, rd_ptr_q;
   logic [15:0] mem_addr_q, rd_addr_q, upload_len_q, len_w;
   logic [7:0]  s_lo_q, s_hi_q, e_lo_q;
   logic [16:0] fill_idx_q, pos_q, total_q, data_end_q, pos_next;

   logic [7:0]  shift_q, cur_q, hold_q;
   logic        hold_vld_q;
   logic [3:0]  bit_cnt_q;
   logic        underrun_q, done_q;

   logic        ptr_ack, data_ack, enter_stream, in_stream;
   logic        byte_done, last_byte, last_done, pos_adv;
   logic        ptr_issue, data_issue, fetch;
   logic [1:0]  ptr_off;

`ifdef UPLOAD_CHECKSUM_EN
   logic [7:0]  csum_q;
   logic        csum_fill;
`endif

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign ss_s     = ss_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign ss_rise  = ss_s & ~ss_prev_q;
   assign ss_fall  = ~ss_s & ss_prev_q;

   assign ptr_ack      = mem_ack & mem_rd_q & rd_ptr_q;
   assign data_ack     = mem_ack & mem_rd_q & ~rd_ptr_q;
   assign enter_stream = (state_q == S_PTR3) & ptr_ack;
   assign in_stream    = (state_q == S_STREAM) | (state_q == S_FLUSH);
   // Pointers may straddle the top of memory, so the length is taken modulo 2^16.
   assign len_w        = {mem_data, e_lo_q} - {s_hi_q, s_lo_q};

   // A byte is finished at the sck fall after its 8th rise; an ss rise at that point also finishes it.
   assign byte_done = (bit_cnt_q == 4'd8) & (sck_fall | ss_rise);
   assign last_byte = (pos_q == total_q - 17'd1);
   assign last_done = in_stream & byte_done & last_byte;
   assign pos_adv   = in_stream & byte_done & ~last_byte;
   assign pos_next  = pos_q + {16'd0, pos_adv};

   assign done       = done_q;
   assign underrun   = underrun_q;
   assign upload_len = upload_len_q;
   assign mem_rd     = mem_rd_q;
   assign mem_addr   = mem_addr_q;
   assign sdo        = shift_q[7];

   // Bring the asynchronous SPI pins into the clk_sys domain and keep last values for edge detect.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sck_sync_q <= '0;
         ss_sync_q  <= '1;
         sck_prev_q <= 1'b0;
         ss_prev_q  <= 1'b1;
      end else begin
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         ss_sync_q  <= {ss_sync_q[SYNC_STAGES-2:0], ss};
         sck_prev_q <= sck_s;
         ss_prev_q  <= ss_s;
      end
   end

   // State register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state: pointer fetch chain, streaming while bytes remain to fetch, flush until the last byte shifts.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start)   state_d = S_PTR0;
         S_PTR0:   if (ptr_ack) state_d = S_PTR1;
         S_PTR1:   if (ptr_ack) state_d = S_PTR2;
         S_PTR2:   if (ptr_ack) state_d = S_PTR3;
         S_PTR3:   if (ptr_ack) state_d = S_STREAM;
         S_STREAM: begin
            if (last_done)                                 state_d = S_IDLE;
            else if ((fill_idx_q == total_q) && !mem_rd_q) state_d = S_FLUSH;
         end
         S_FLUSH:  if (last_done) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs and read requests decoded from the state.
   always_comb begin
      busy       = (state_q != S_IDLE);
      ptr_issue  = 1'b0;
      ptr_off    = 2'd0;
      case (state_q)
         S_PTR0: begin ptr_issue = ~mem_rd_q; ptr_off = 2'd0; end
         S_PTR1: begin ptr_issue = ~mem_rd_q; ptr_off = 2'd1; end
         S_PTR2: begin ptr_issue = ~mem_rd_q; ptr_off = 2'd2; end
         S_PTR3: begin ptr_issue = ~mem_rd_q; ptr_off = 2'd3; end
         default: ;
      endcase
      fetch      = (state_q == S_STREAM) & ~hold_vld_q & (fill_idx_q < total_q);
      data_issue = fetch & (fill_idx_q < data_end_q) & ~mem_rd_q;
`ifdef UPLOAD_CHECKSUM_EN
      csum_fill  = fetch & (fill_idx_q >= data_end_q);
`endif
   end

   // Memory side: one request at a time, pointer capture, stream setup and fetch bookkeeping.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mem_rd_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         mem_addr_q   <= '0;
         s_lo_q       <= '0;
         s_hi_q       <= '0;
         e_lo_q       <= '0;
         rd_addr_q    <= '0;
         fill_idx_q   <= '0;
         total_q      <= '0;
         data_end_q   <= '0;
         upload_len_q <= '0;
      end else begin
         if (mem_rd_q && mem_ack) begin
            mem_rd_q <= 1'b0;
         end else if (ptr_issue) begin
            mem_rd_q   <= 1'b1;
            rd_ptr_q   <= 1'b1;
            mem_addr_q <= PTR_BASE + {14'd0, ptr_off};
         end else if (data_issue) begin
            mem_rd_q   <= 1'b1;
            rd_ptr_q   <= 1'b0;
            mem_addr_q <= rd_addr_q;
         end
         if (ptr_ack) begin
            case (state_q)
               S_PTR0:  s_lo_q <= mem_data;
               S_PTR1:  s_hi_q <= mem_data;
               S_PTR2:  e_lo_q <= mem_data;
               default: ;
            endcase
         end
         if (enter_stream) begin
            rd_addr_q    <= {s_hi_q, s_lo_q};
            fill_idx_q   <= 17'd2;
            data_end_q   <= {1'b0, len_w} + 17'd2;
            total_q      <= {1'b0, len_w} + 17'd2 + TRAILER;
            upload_len_q <= len_w + 16'd2 + TRAILER[15:0];
         end else if (data_ack && in_stream) begin
            rd_addr_q  <= rd_addr_q + 16'd1;
            fill_idx_q <= fill_idx_q + 17'd1;
         end
`ifdef UPLOAD_CHECKSUM_EN
         else if (csum_fill) begin
            fill_idx_q <= fill_idx_q + 17'd1;
         end
`endif
      end
   end

   // SPI side: shift register, one-byte holding register, stream position, underrun and done.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         shift_q    <= PAD_BYTE;
         cur_q      <= PAD_BYTE;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         bit_cnt_q  <= '0;
         pos_q      <= '0;
         underrun_q <= 1'b0;
         done_q     <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if ((state_q == S_IDLE) && start) underrun_q <= 1'b0;
         if (enter_stream) begin
            // Header bytes come from the captured pointer, no memory access.
            shift_q    <= s_lo_q;
            cur_q      <= s_lo_q;
            hold_q     <= s_hi_q;
            hold_vld_q <= 1'b1;
            bit_cnt_q  <= '0;
            pos_q      <= '0;
`ifdef UPLOAD_CHECKSUM_EN
            csum_q     <= s_lo_q;
`endif
         end else begin
            if (byte_done) begin
               bit_cnt_q <= '0;
               if (last_done) begin
                  shift_q <= PAD_BYTE;
                  cur_q   <= PAD_BYTE;
                  done_q  <= 1'b1;
               end else if (in_stream) begin
                  pos_q <= pos_q + 17'd1;
                  if (hold_vld_q) begin
                     shift_q    <= hold_q;
                     cur_q      <= hold_q;
                     hold_vld_q <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
                     csum_q     <= csum_q ^ hold_q;
`endif
                  end else begin
                     shift_q    <= 8'h00;
                     cur_q      <= 8'h00;
                     underrun_q <= 1'b1;
                  end
               end else begin
                  shift_q <= PAD_BYTE;
                  cur_q   <= PAD_BYTE;
               end
            end else if (ss_rise || ss_fall) begin
               // Select change mid-byte: restart the current byte from its MSB.
               shift_q   <= cur_q;
               bit_cnt_q <= '0;
            end else if (!ss_s) begin
               if (sck_rise && (bit_cnt_q != 4'd8)) bit_cnt_q <= bit_cnt_q + 4'd1;
               if (sck_fall && (bit_cnt_q != 4'd0)) shift_q <= {shift_q[6:0], 1'b0};
            end
            // A byte whose slot was already passed by an underrun is discarded.
            if (data_ack && in_stream && (fill_idx_q > pos_next)) begin
               hold_q     <= mem_data;
               hold_vld_q <= 1'b1;
            end
`ifdef UPLOAD_CHECKSUM_EN
            if (csum_fill && (fill_idx_q > pos_next)) begin
               hold_q     <= csum_q;
               hold_vld_q <= 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_prg_upload.sv
// tb/tb_prg_upload.sv - scoreboard testbench for prg_upload

module tb_prg_upload;

   logic        clk_sys = 1'b0;
   logic        reset_n, start, mem_ack, sck, ss;
   logic [7:0]  mem_data;
   logic        busy, done, underrun, mem_rd, sdo;
   logic [15:0] upload_len, mem_addr;

   logic [7:0]  mem [0:65535];
   logic [15:0] rd_log [$];
   logic [7:0]  exp_q [$];
   logic [15:0] exp_len;
   int          lat, wait_cnt, done_cnt;
   int          n_checks, n_fail;

   prg_upload dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
      .underrun(underrun), .upload_len(upload_len), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_ack(mem_ack), .sck(sck), .ss(ss), .sdo(sdo)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) if (done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory responder: acks each request after lat idle cycles, logs the address.
   initial begin
      mem_ack = 1'b0; mem_data = 8'h00; wait_cnt = 0;
      forever begin
         @(negedge clk_sys);
         if (mem_ack) mem_ack = 1'b0;
         else if (mem_rd === 1'b1) begin
            if (wait_cnt >= lat) begin
               mem_data = mem[mem_addr];
               mem_ack  = 1'b1;
               rd_log.push_back(mem_addr);
               wait_cnt = 0;
            end else wait_cnt++;
         end else wait_cnt = 0;
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Program pointers into zero page and queue the expected stream.
   task automatic setup(input logic [15:0] sa, input logic [15:0] ea, input bit zero_data);
      logic [15:0] a, len;
      logic [7:0]  x, b;
      mem[16'h002B] = sa[7:0];
      mem[16'h002C] = sa[15:8];
      mem[16'h002D] = ea[7:0];
      mem[16'h002E] = ea[15:8];
      exp_q.delete();
      exp_q.push_back(sa[7:0]);
      exp_q.push_back(sa[15:8]);
      x   = sa[7:0] ^ sa[15:8];
      len = ea - sa;
      a   = sa;
      for (int i = 0; i < int'(len); i++) begin
         b = zero_data ? 8'h00 : mem[a];
         exp_q.push_back(b);
         x = x ^ b;
         a = a + 16'd1;
      end
      exp_len = len + 16'd2;
`ifdef UPLOAD_CHECKSUM_EN
      exp_q.push_back(zero_data ? 8'h00 : x);
      exp_len = exp_len + 16'd1;
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_underrun"}, underrun, 0);
      check({tag, "_upload_len"}, upload_len, 0);
      check({tag, "_mem_rd"}, mem_rd, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_sdo"}, sdo, 1);
   endtask

   task automatic pulse_start();
      @(negedge clk_sys); start = 1'b1;
      @(negedge clk_sys); start = 1'b0;
   endtask

   task automatic wait_reads(input int n, input int budget);
      for (int i = 0; i < budget && rd_log.size() < n; i++) @(negedge clk_sys);
      check("rd_wait", rd_log.size() >= n, 1);
   endtask

   // Mode-0 master: sample sdo just before each rising edge, sck = clk_sys/8.
   task automatic spi_bits(input int nbits, output logic [7:0] b);
      b = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         #40; b = {b[6:0], sdo};
         sck = 1'b1; #40; sck = 1'b0;
      end
   endtask

   task automatic ss_low();
      @(negedge clk_sys); ss = 1'b0; #80;
   endtask

   task automatic ss_high();
      #40; ss = 1'b1; #80;
   endtask

   task automatic rx_expect(input string tag);
      logic [7:0] b;
      spi_bits(8, b);
      if (exp_q.size() == 0) check({tag, "_sb_underflow"}, exp_q.size(), 1);
      else check(tag, b, exp_q.pop_front());
   endtask

   task automatic rx_all();
      while (exp_q.size() > 1) rx_expect("byte");
      check("done_early", done_cnt, 0);
      rx_expect("last_byte");
      repeat (10) @(negedge clk_sys);
      check("done_cnt", done_cnt, 1);
      check("busy_end", busy, 0);
   endtask

   task automatic begin_upload(input int budget);
      rd_log.delete();
      done_cnt = 0;
      pulse_start();
      check("busy_start", busy, 1);
      wait_reads(4, budget);
      repeat (5) @(negedge clk_sys);
      check("upload_len", upload_len, exp_len);
   endtask

   initial begin
      logic [7:0] b, t;
      n_checks = 0; n_fail = 0; lat = 0; done_cnt = 0;
      start = 1'b0; sck = 1'b0; ss = 1'b1; reset_n = 1'b0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      repeat (2) @(negedge clk_sys);
      check_reset_outputs("reset");
      reset_n = 1'b1;
      @(negedge clk_sys);

      // Basic upload
      mem[16'h1001] = 8'hA9; mem[16'h1002] = 8'h00; mem[16'h1003] = 8'h60; mem[16'h1004] = 8'hEA;
      setup(16'h1001, 16'h1005, 1'b0);
      begin_upload(200);
      ss_low();
      rx_all();
      spi_bits(8, b);
      check("pad_basic", b, 8'hFF);
      ss_high();
      check("basic_reads", rd_log.size(), 8);
      if (rd_log.size() == 8) begin
         check("rd_ptr0", rd_log[0], 16'h002B);
         check("rd_ptr3", rd_log[3], 16'h002E);
         check("rd_data0", rd_log[4], 16'h1001);
         check("rd_data3", rd_log[7], 16'h1004);
      end

      // Empty program
      setup(16'h1001, 16'h1001, 1'b0);
      begin_upload(200);
      ss_low();
      rx_all();
      ss_high();
      check("empty_reads", rd_log.size(), 4);

      // ss abort in the first data byte
      setup(16'h1001, 16'h1005, 1'b0);
      begin_upload(200);
      ss_low();
      rx_expect("abort_hdr0");
      rx_expect("abort_hdr1");
      t = exp_q[0];
      spi_bits(3, b);
      check("abort_bits", b, {5'd0, t[7:5]});
      ss_high();
      ss_low();
      rx_all();
      ss_high();

      // Wrap across FFFF and pad after done
      mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33;
      setup(16'hFFFE, 16'h0001, 1'b0);
      begin_upload(200);
      ss_low();
      rx_all();
      spi_bits(8, b);
      check("pad_wrap", b, 8'hFF);
      ss_high();
      check("wrap_reads", rd_log.size(), 7);
      if (rd_log.size() == 7) begin
         check("wrap_a0", rd_log[4], 16'hFFFE);
         check("wrap_a1", rd_log[5], 16'hFFFF);
         check("wrap_a2", rd_log[6], 16'h0000);
      end

      // Slow memory: data never arrives in time
      lat = 400;
      setup(16'h1001, 16'h1003, 1'b1);
      begin_upload(2500);
      ss_low();
      rx_all();
      ss_high();
      check("underrun_set", underrun, 1);
      lat = 0;
      repeat (10) @(negedge clk_sys);
      setup(16'h1001, 16'h1005, 1'b0);
      rd_log.delete();
      done_cnt = 0;
      pulse_start();
      check("underrun_clr", underrun, 0);
      wait_reads(4, 200);
      repeat (5) @(negedge clk_sys);
      ss_low();
      rx_all();
      ss_high();
      check("underrun_after", underrun, 0);

      // Reset in the middle of the stream
      setup(16'h1001, 16'h1005, 1'b0);
      begin_upload(200);
      ss_low();
      rx_expect("rst_hdr0");
      rx_expect("rst_hdr1");
      spi_bits(4, b);
      #3; reset_n = 1'b0;
      #1; check_reset_outputs("midrst");
      ss = 1'b1;
      exp_q.delete();
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (3) @(negedge clk_sys);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
